// File: rtl/frame_draw_scheduler_if.sv
// Request/pixel bus between rectangle requesters and frame_draw_scheduler.
// master = requester side (drives req fields and frame_start), slave = scheduler.
interface frame_draw_scheduler_if #(
  parameter int N_REQ = 4
);
  logic                  frame_start;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*10-1:0]   req_x;
  logic [N_REQ*10-1:0]   req_y;
  logic [N_REQ*10-1:0]   req_w;
  logic [N_REQ*10-1:0]   req_h;
  logic [N_REQ*16-1:0]   req_color;
  logic [N_REQ-1:0]      ack;
  logic [N_REQ-1:0]      done;
  logic [9:0]            program_x;
  logic [9:0]            program_y;
  logic [15:0]           program_data;
  logic                  program_we;
  logic                  busy;
  logic                  frame_overrun;

  modport master (
    output frame_start, req, req_x, req_y, req_w, req_h, req_color,
    input  ack, done, program_x, program_y, program_data, program_we, busy, frame_overrun
  );

  modport slave (
    input  frame_start, req, req_x, req_y, req_w, req_h, req_color,
    output ack, done, program_x, program_y, program_data, program_we, busy, frame_overrun
  );
endinterface

// File: rtl/frame_draw_scheduler.sv
// Round-robin rectangle fill scheduler feeding SRAM write slots, one pixel per SLOT_PERIOD cycles.
// Optional macro FRAME_DRAW_CLIP_EN suppresses writes for pixels outside 640x480.
module frame_draw_scheduler #(
  parameter int N_REQ       = 4,
  parameter int SLOT_PERIOD = 2
) (
  input logic                  sram_clk,
  input logic                  reset,
  frame_draw_scheduler_if.slave bus
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_PERIOD - 1);
  localparam logic [RW-1:0] RR_LAST   = RW'(N_REQ - 1);

`ifdef FRAME_DRAW_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, DRAW} state_t;

  function automatic logic pix_visible(input logic [9:0] x, input logic [9:0] y);
    return !CLIP_EN || ((x < 10'd640) && (y < 10'd480));
  endfunction

  logic [9:0]  rx [N_REQ];
  logic [9:0]  ry [N_REQ];
  logic [9:0]  rw [N_REQ];
  logic [9:0]  rh [N_REQ];
  logic [15:0] rc [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign rx[i] = bus.req_x[10*i +: 10];
    assign ry[i] = bus.req_y[10*i +: 10];
    assign rw[i] = bus.req_w[10*i +: 10];
    assign rh[i] = bus.req_h[10*i +: 10];
    assign rc[i] = bus.req_color[16*i +: 16];
  end

  state_t           state_q, state_d;
  logic [RW-1:0]    rr_q, rr_d;
  logic [RW-1:0]    g_q, g_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [9:0]       x0_q, x0_d;
  logic [9:0]       xe_q, xe_d;
  logic [9:0]       ye_q, ye_d;
  logic [9:0]       program_x_q, program_x_d;
  logic [9:0]       program_y_q, program_y_d;
  logic [15:0]      program_data_q, program_data_d;
  logic             program_we_q, program_we_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             frame_overrun_q, frame_overrun_d;

  logic             found;
  logic [RW-1:0]    gsel;
  logic [RW-1:0]    cand;

  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    g_d             = g_q;
    zero_d          = zero_q;
    cnt_d           = cnt_q;
    x0_d            = x0_q;
    xe_d            = xe_q;
    ye_d            = ye_q;
    program_x_d     = program_x_q;
    program_y_d     = program_y_q;
    program_data_d  = program_data_q;
    program_we_d    = program_we_q;
    ack_d           = '0;
    done_d          = '0;
    frame_overrun_d = 1'b0;
    found           = 1'b0;
    gsel            = '0;
    cand            = '0;

    // first requesting index at or after the round-robin pointer
    for (int k = 0; k < N_REQ; k++) begin
      cand = RW'((int'(rr_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        gsel  = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (!bus.frame_start && found) begin
          g_d            = gsel;
          rr_d           = (gsel == RR_LAST) ? '0 : gsel + 1'b1;
          ack_d[gsel]    = 1'b1;
          x0_d           = rx[gsel];
          xe_d           = rx[gsel] + rw[gsel] - 10'd1;
          ye_d           = ry[gsel] + rh[gsel] - 10'd1;
          zero_d         = (rw[gsel] == '0) || (rh[gsel] == '0);
          cnt_d          = '0;
          program_x_d    = rx[gsel];
          program_y_d    = ry[gsel];
          program_data_d = rc[gsel];
          program_we_d   = !zero_d && pix_visible(rx[gsel], ry[gsel]);
          state_d        = DRAW;
        end
      end
      DRAW: begin
        if (bus.frame_start) begin
          // abort: the rest of this rectangle belongs to a frame already swapped out
          program_we_d    = 1'b0;
          frame_overrun_d = 1'b1;
          state_d         = IDLE;
        end else if (zero_q) begin
          done_d[g_q] = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == SLOT_LAST) begin
          cnt_d = '0;
          if (program_x_q == xe_q) begin
            if (program_y_q == ye_q) begin
              program_we_d = 1'b0;
              done_d[g_q]  = 1'b1;
              state_d      = IDLE;
            end else begin
              program_x_d  = x0_q;
              program_y_d  = program_y_q + 10'd1;
              program_we_d = pix_visible(x0_q, program_y_q + 10'd1);
            end
          end else begin
            program_x_d  = program_x_q + 10'd1;
            program_we_d = pix_visible(program_x_q + 10'd1, program_y_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRAW);
  end

  always_ff @(posedge sram_clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_q            <= '0;
      g_q             <= '0;
      zero_q          <= 1'b0;
      cnt_q           <= '0;
      program_x_q     <= '0;
      program_y_q     <= '0;
      program_data_q  <= '0;
      program_we_q    <= 1'b0;
      ack_q           <= '0;
      done_q          <= '0;
      busy_q          <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_q            <= rr_d;
      g_q             <= g_d;
      zero_q          <= zero_d;
      cnt_q           <= cnt_d;
      program_x_q     <= program_x_d;
      program_y_q     <= program_y_d;
      program_data_q  <= program_data_d;
      program_we_q    <= program_we_d;
      ack_q           <= ack_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  // latched rectangle bounds are only consulted in DRAW, after a grant has loaded them
  always_ff @(posedge sram_clk) begin
    x0_q <= x0_d;
    xe_q <= xe_d;
    ye_q <= ye_d;
  end

  assign bus.ack           = ack_q;
  assign bus.done          = done_q;
  assign bus.program_x     = program_x_q;
  assign bus.program_y     = program_y_q;
  assign bus.program_data  = program_data_q;
  assign bus.program_we    = program_we_q;
  assign bus.busy          = busy_q;
  assign bus.frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: directed scenarios then random traffic, all checked
// each cycle against a time-since-grant model of the rectangle walk.
module tb_frame_draw_scheduler;
  localparam int N_REQ = 4;
  localparam int SP    = 2;

  logic sram_clk = 1'b0;
  logic reset;

  frame_draw_scheduler_if #(.N_REQ(N_REQ)) bus();

  frame_draw_scheduler #(.N_REQ(N_REQ), .SLOT_PERIOD(SP)) dut (
    .sram_clk (sram_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 sram_clk = ~sram_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_active, m_g, m_t, m_rr;
  int          m_x0, m_y0, m_w, m_h;
  logic [15:0] m_col;
  logic [N_REQ-1:0] e_ack, e_done;
  logic        e_we, e_busy, e_ovr, e_xy_zero;
  logic [9:0]  e_x, e_y;
  logic [15:0] e_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dur();
    int n;
    n = m_w * m_h;
    return (n == 0) ? 1 : n * SP;
  endfunction

  task automatic set_pixel(input int p);
    e_x    = 10'((m_x0 + p % m_w) % 1024);
    e_y    = 10'((m_y0 + p / m_w) % 1024);
    e_data = m_col;
`ifdef FRAME_DRAW_CLIP_EN
    e_we   = (e_x < 640) && (e_y < 480);
`else
    e_we   = 1'b1;
`endif
  endtask

  // expected outputs after the coming clock edge, from the inputs currently applied
  task automatic model_edge();
    int g;
    e_ack = '0; e_done = '0; e_ovr = 1'b0; e_we = 1'b0; e_xy_zero = 1'b0;
    if (reset) begin
      m_active = 0; m_rr = 0; e_xy_zero = 1'b1;
      e_x = '0; e_y = '0; e_data = '0;
    end else if (m_active != 0) begin
      if (bus.frame_start) begin
        m_active = 0; e_ovr = 1'b1;
      end else begin
        m_t++;
        if (m_t == dur()) begin
          e_done[m_g] = 1'b1; m_active = 0;
        end else begin
          set_pixel(m_t / SP);
        end
      end
    end else if (!bus.frame_start && bus.req != '0) begin
      g = -1;
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && bus.req[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
      m_g   = g;
      m_x0  = int'(bus.req_x[g*10 +: 10]);
      m_y0  = int'(bus.req_y[g*10 +: 10]);
      m_w   = int'(bus.req_w[g*10 +: 10]);
      m_h   = int'(bus.req_h[g*10 +: 10]);
      m_col = bus.req_color[g*16 +: 16];
      m_rr  = (g + 1) % N_REQ;
      m_active = 1; m_t = 0;
      e_ack[g] = 1'b1;
      if (m_w * m_h > 0) set_pixel(0);
    end
    e_busy = (m_active != 0);
  endtask

  task automatic check_outputs();
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("program_we", 32'(bus.program_we), 32'(e_we));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("frame_overrun", 32'(bus.frame_overrun), 32'(e_ovr));
    if (e_we || e_xy_zero) begin
      chk("program_x", 32'(bus.program_x), 32'(e_x));
      chk("program_y", 32'(bus.program_y), 32'(e_y));
      chk("program_data", 32'(bus.program_data), 32'(e_data));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge sram_clk);
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int i, input int x, input int y, input int w, input int h,
                         input logic [15:0] c);
    bus.req_x[i*10 +: 10]     = 10'(x);
    bus.req_y[i*10 +: 10]     = 10'(y);
    bus.req_w[i*10 +: 10]     = 10'(w);
    bus.req_h[i*10 +: 10]     = 10'(h);
    bus.req_color[i*16 +: 16] = c;
    bus.req[i]                = 1'b1;
  endtask

  task automatic rand_fields(input int i);
    int x;
    x = ($urandom_range(1) == 1) ? int'($urandom_range(1023)) : int'($urandom_range(20));
    set_req(i, x, int'($urandom_range(1023)), int'($urandom_range(5)),
            int'($urandom_range(4)), 16'($urandom));
  endtask

  int we_cnt, done_at, n_ord;
  int ord [4];

  initial begin
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
    bus.req_color = '0;
    m_active = 0; m_rr = 0; m_g = 0; m_t = 0;
    m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_col = '0;
    step(); step();
    reset = 1'b0;
    step();

    // single rectangle
    set_req(0, 10, 20, 3, 2, 16'hF800);
    step();
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_first_x", 32'(bus.program_x), 32'd10);
    chk("t1_first_y", 32'(bus.program_y), 32'd20);
    bus.req[0] = 1'b0;
    we_cnt = 0; done_at = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus.program_we) we_cnt++;
      if (bus.done[0]) done_at = c;
    end
    chk("t1_we_cycles_after_first", 32'(we_cnt), 32'd11);
    chk("t1_done_at", 32'(done_at), 32'd12);

    // arbitration from reset: 0, then 2 ahead of the still-requesting 0
    reset = 1'b1;
    set_req(0, 100, 100, 1, 1, 16'h07E0);
    set_req(2, 200, 50, 1, 1, 16'h001F);
    step();
    reset = 1'b0;
    n_ord = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      for (int i = 0; i < N_REQ; i++)
        if (bus.ack[i] && n_ord < 4) begin ord[n_ord] = i; n_ord++; end
    end
    chk("t2_grant0", 32'(ord[0]), 32'd0);
    chk("t2_grant1", 32'(ord[1]), 32'd2);
    chk("t2_grant2", 32'(ord[2]), 32'd0);
    bus.req = '0;
    for (int c = 0; c < 6; c++) step();

    // zero-size rectangle
    set_req(1, 5, 5, 0, 5, 16'hFFFF);
    step();
    chk("t3_ack", 32'(bus.ack), 32'h2);
    chk("t3_we", 32'(bus.program_we), 32'd0);
    bus.req[1] = 1'b0;
    step();
    chk("t3_done", 32'(bus.done), 32'h2);
    chk("t3_we_done", 32'(bus.program_we), 32'd0);
    step();

    // frame swap after five pixels of an 8x8 rectangle
    set_req(0, 300, 200, 8, 8, 16'h1234);
    step();
    bus.req[0] = 1'b0;
    for (int c = 1; c < 5 * SP; c++) step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk("t4_we", 32'(bus.program_we), 32'd0);
    chk("t4_overrun", 32'(bus.frame_overrun), 32'd1);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_done", 32'(bus.done), 32'd0);
    for (int c = 0; c < 4; c++) step();

    // reset while drawing; pointer returns to requester 0
    set_req(1, 40, 40, 4, 4, 16'hAAAA);
    step();
    bus.req[1] = 1'b0;
    for (int c = 0; c < 3; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_we", 32'(bus.program_we), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_x", 32'(bus.program_x), 32'd0);
    chk("t6_data", 32'(bus.program_data), 32'd0);
    set_req(0, 1, 2, 2, 1, 16'h0F0F);
    set_req(2, 3, 4, 2, 1, 16'hF0F0);
    step();
    chk("t6_regrant", 32'(bus.ack), 32'h1);
    bus.req = '0;
    for (int c = 0; c < 8; c++) step();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(1) == 1) bus.req[i] = 1'b0;
          else rand_fields(i);
        end else if (!bus.req[i]) begin
          if ($urandom_range(3) == 0) rand_fields(i);
        end else if ($urandom_range(19) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.frame_start = ($urandom_range(49) == 0);
      reset = ($urandom_range(299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
